rvfi_stream_checker: RTL and testbench
======================================

# rvfi_stream_checker

Retirement-stream checker for the RVFI co-simulation path. It consumes two retirement streams: the DUT stream, and the stream the ISS-backed reference model emits. It buffers each stream in its own FIFO, pairs entries strictly in retirement order, and compares the architectural fields. It reports mismatches, counts results, and flags buffer overflow and stream stall. It sits downstream of the reference model and DUT tracer, inside the co-sim harness.

## Interface
Parameters:
- XLEN, 32, width of PC and register data.
- DEPTH, 8, entries per FIFO; power of two, ≥ 2.
- TIMEOUT, 1000, cycles one stream may wait unpaired before timeout; ≥ 1.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- dut_valid_i  input  1  DUT retirement valid; no backpressure.
- dut_order_i  input  64  DUT instruction order.
- dut_pc_i  input  XLEN  DUT PC of retired instruction.
- dut_insn_i  input  32  DUT instruction word.
- dut_trap_i  input  1  DUT trap flag.
- dut_rd_addr_i  input  5  DUT destination register.
- dut_rd_wdata_i  input  XLEN  DUT destination write data.
- ref_valid_i, ref_order_i, ref_pc_i, ref_insn_i, ref_trap_i, ref_rd_addr_i, ref_rd_wdata_i  input  same widths  reference-model stream, same meaning.
- mismatch_o  output  1  one-cycle pulse per mismatching pair.
- mismatch_field_o  output  6  per-field miss mask, held until next compare: {order, pc, insn, trap, rd_addr, rd_wdata}, bit 5 = order.
- mismatch_order_o  output  64  DUT order of the most recent mismatching pair.
- match_count_o  output  32  matching pairs, saturating.
- mismatch_count_o  output  32  mismatching pairs, saturating.
- overflow_o  output  1  sticky; an entry was dropped on a full FIFO.
- timeout_o  output  1  sticky; a stream waited TIMEOUT cycles unpaired.
- dut_level_o, ref_level_o  output  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
Reset behaviour:
- Every output resets to 0.
- Both FIFOs empty, timeout counter 0.
- Reset asserted mid-operation discards all buffered entries and in-flight results immediately.

Push:
- A valid stream input is written to its FIFO on the same edge.
- Full and no pop this cycle: the entry is dropped and overflow_o is set.
- Full with a pop this cycle: the push is accepted and no overflow occurs.

Compare and pop:
- When both FIFOs are non-empty, both heads pop on the same edge.
- Fields are compared combinationally from the heads; the result is registered on the pop edge.
- rd_addr is compared always.
- rd_wdata is compared only when both rd_addr are non-zero. If both are 0, the rd_wdata bit is 0.
- Any mask bit set: mismatch_o pulses, mismatch_count_o increments, and mismatch_order_o latches the DUT order.
- Otherwise match_count_o increments.
- Counters saturate at 32'hFFFF_FFFF.

Timeout counter:
- Increments on each cycle where exactly one FIFO is non-empty and no pop occurs.
- Clears on a pop, or when both FIFOs are empty.
- Reaching TIMEOUT sets timeout_o; the counter then holds.

Other rules:
- Sticky flags clear only on reset.
- No state machine beyond the FIFOs and timeout counter; operation is a fully pipelined single-stage compare.

## Timing
- A valid input at edge N is visible at the FIFO head after edge N. The earliest pop is at edge N+1.
- mismatch_o and the mask are valid in the cycle after the pop edge. From simultaneous valids: sample at N, pop at N+1, result asserted in cycle N+1..N+2.
- Throughput is one compare per cycle. Push and pop on the same FIFO in the same cycle leave the level unchanged.
- Level outputs are registered and reflect pushes and pops after the edge.
- Streams may be skewed by up to DEPTH entries without loss.

## Test plan
- Identical streams: 20 retirements on both sides, same cycles → match_count_o=20, mismatch_count_o=0, no flags.
- Skew: DUT sends 5 retirements, the reference sends the same 5 starting 6 cycles later → 5 matches; dut_level_o peaks at 5 then drains to 0.
- Field errors:
  - One pair with ref pc+4 → mismatch_o pulses once, mask=6'b010000, mismatch_order_o equals that order.
  - rd_addr=0 with differing wdata → match.
- Overflow: DEPTH=8; DUT sends 9 back-to-back, the reference is silent → overflow_o=1, dut_level_o=8. After reset, all outputs are 0.
- Timeout: TIMEOUT=10; one DUT entry, no reference → timeout_o rises on the 10th unpaired cycle. A pair arriving earlier (cycle 9) keeps timeout_o=0.
- Reset mid-stream: assert rst_i with 3 entries buffered → levels go to 0 asynchronously. Post-reset identical streams match cleanly.

Source files
------------

// File: rtl/rvfi_stream_checker.sv
// rvfi_stream_checker: pairs DUT and reference-model retirement streams in
// retirement order through two FIFOs and compares the architectural fields.
// Results, saturating counters, overflow and stall flags are registered.

// Simple synchronous FIFO with registered occupancy; the head is read combinationally.
module rvfi_stream_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wr_ptr_q] = data_i;
    wr_ptr_d = wr_ptr_q + AW'(push_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_i);
    level_d  = level_q + LW'(push_i) - LW'(pop_i);
  end

  // Storage carries no reset; pointers and level define validity.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Pointer and level registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
endmodule

module rvfi_stream_checker #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       dut_valid_i,
  input  logic [63:0]                dut_order_i,
  input  logic [XLEN-1:0]            dut_pc_i,
  input  logic [31:0]                dut_insn_i,
  input  logic                       dut_trap_i,
  input  logic [4:0]                 dut_rd_addr_i,
  input  logic [XLEN-1:0]            dut_rd_wdata_i,
  input  logic                       ref_valid_i,
  input  logic [63:0]                ref_order_i,
  input  logic [XLEN-1:0]            ref_pc_i,
  input  logic [31:0]                ref_insn_i,
  input  logic                       ref_trap_i,
  input  logic [4:0]                 ref_rd_addr_i,
  input  logic [XLEN-1:0]            ref_rd_wdata_i,
  output logic                       mismatch_o,
  output logic [5:0]                 mismatch_field_o,
  output logic [63:0]                mismatch_order_o,
  output logic [31:0]                match_count_o,
  output logic [31:0]                mismatch_count_o,
  output logic                       overflow_o,
  output logic                       timeout_o,
  output logic [$clog2(DEPTH+1)-1:0] dut_level_o,
  output logic [$clog2(DEPTH+1)-1:0] ref_level_o
);
  localparam int unsigned TW = $clog2(TIMEOUT+1);
  localparam int unsigned EW = 64 + XLEN + 32 + 1 + 5 + XLEN;

  typedef struct packed {
    logic [63:0]     order;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            trap;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
  } entry_t;

  entry_t dut_in, ref_in, dut_head, ref_head;
  logic [EW-1:0] dut_head_raw, ref_head_raw;
  logic dut_empty, dut_full, ref_empty, ref_full;
  logic pop, dut_push, ref_push, drop;
  logic [5:0] mask;

  logic          mismatch_q, mismatch_d;
  logic [5:0]    field_q, field_d;
  logic [63:0]   order_q, order_d;
  logic [31:0]   match_cnt_q, match_cnt_d;
  logic [31:0]   mm_cnt_q, mm_cnt_d;
  logic          overflow_q, overflow_d;
  logic          timeout_q, timeout_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Pack incoming retirements and gate pushes against full FIFOs.
  always_comb begin
    dut_in = '{order: dut_order_i, pc: dut_pc_i, insn: dut_insn_i, trap: dut_trap_i,
               rd_addr: dut_rd_addr_i, rd_wdata: dut_rd_wdata_i};
    ref_in = '{order: ref_order_i, pc: ref_pc_i, insn: ref_insn_i, trap: ref_trap_i,
               rd_addr: ref_rd_addr_i, rd_wdata: ref_rd_wdata_i};
    pop      = !dut_empty && !ref_empty;
    // A full FIFO still accepts when its head leaves on the same edge.
    dut_push = dut_valid_i && (!dut_full || pop);
    ref_push = ref_valid_i && (!ref_full || pop);
    drop     = (dut_valid_i && dut_full && !pop) || (ref_valid_i && ref_full && !pop);
  end

  rvfi_stream_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_dut_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (dut_push),
    .pop_i   (pop),
    .data_i  (dut_in),
    .head_o  (dut_head_raw),
    .level_o (dut_level_o),
    .empty_o (dut_empty),
    .full_o  (dut_full)
  );

  rvfi_stream_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_ref_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ref_push),
    .pop_i   (pop),
    .data_i  (ref_in),
    .head_o  (ref_head_raw),
    .level_o (ref_level_o),
    .empty_o (ref_empty),
    .full_o  (ref_full)
  );

  assign dut_head = dut_head_raw;
  assign ref_head = ref_head_raw;

  // Field-by-field compare of the two heads; wdata only counts when both write a real register.
  always_comb begin
    mask    = '0;
    mask[5] = (dut_head.order   != ref_head.order);
    mask[4] = (dut_head.pc      != ref_head.pc);
    mask[3] = (dut_head.insn    != ref_head.insn);
    mask[2] = (dut_head.trap    != ref_head.trap);
    mask[1] = (dut_head.rd_addr != ref_head.rd_addr);
    mask[0] = (dut_head.rd_addr != '0) && (ref_head.rd_addr != '0) &&
              (dut_head.rd_wdata != ref_head.rd_wdata);
  end

  // Result, counter, sticky-flag and stall-counter next state.
  always_comb begin
    mismatch_d  = 1'b0;
    field_d     = field_q;
    order_d     = order_q;
    match_cnt_d = match_cnt_q;
    mm_cnt_d    = mm_cnt_q;
    if (pop) begin
      field_d = mask;
      if (|mask) begin
        mismatch_d = 1'b1;
        order_d    = dut_head.order;
        if (mm_cnt_q != '1) mm_cnt_d = mm_cnt_q + 32'd1;
      end else if (match_cnt_q != '1) begin
        match_cnt_d = match_cnt_q + 32'd1;
      end
    end
    overflow_d = overflow_q | drop;
    tmo_cnt_d  = tmo_cnt_q;
    if (pop || (dut_empty && ref_empty)) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TW'(TIMEOUT)) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
    timeout_d = timeout_q | (tmo_cnt_d == TW'(TIMEOUT));
  end

  // Result and status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mismatch_q  <= 1'b0;
      field_q     <= '0;
      order_q     <= '0;
      match_cnt_q <= '0;
      mm_cnt_q    <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      mismatch_q  <= mismatch_d;
      field_q     <= field_d;
      order_q     <= order_d;
      match_cnt_q <= match_cnt_d;
      mm_cnt_q    <= mm_cnt_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign mismatch_o       = mismatch_q;
  assign mismatch_field_o = field_q;
  assign mismatch_order_o = order_q;
  assign match_count_o    = match_cnt_q;
  assign mismatch_count_o = mm_cnt_q;
  assign overflow_o       = overflow_q;
  assign timeout_o        = timeout_q;
endmodule

// File: tb/tb_rvfi_stream_checker.sv
// Directed bench for rvfi_stream_checker: a table of field-error pairs plus
// hand-written skew, overflow, timeout and reset sequences.
module tb_rvfi_stream_checker;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 10;
  localparam int unsigned LW      = $clog2(DEPTH+1);

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
  } entry_t;

  typedef struct {
    entry_t     d;
    entry_t     r;
    logic [5:0] exp_mask;
  } vec_t;

  logic clk, rst_i;
  logic dut_valid_i, ref_valid_i;
  logic [63:0] dut_order_i, ref_order_i;
  logic [31:0] dut_pc_i, ref_pc_i, dut_insn_i, ref_insn_i;
  logic dut_trap_i, ref_trap_i;
  logic [4:0] dut_rd_addr_i, ref_rd_addr_i;
  logic [31:0] dut_rd_wdata_i, ref_rd_wdata_i;
  logic mismatch_o;
  logic [5:0] mismatch_field_o;
  logic [63:0] mismatch_order_o;
  logic [31:0] match_count_o, mismatch_count_o;
  logic overflow_o, timeout_o;
  logic [LW-1:0] dut_level_o, ref_level_o;

  int unsigned n_vec = 0;
  int unsigned n_fail = 0;

  rvfi_stream_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .dut_valid_i(dut_valid_i), .dut_order_i(dut_order_i), .dut_pc_i(dut_pc_i),
    .dut_insn_i(dut_insn_i), .dut_trap_i(dut_trap_i), .dut_rd_addr_i(dut_rd_addr_i),
    .dut_rd_wdata_i(dut_rd_wdata_i),
    .ref_valid_i(ref_valid_i), .ref_order_i(ref_order_i), .ref_pc_i(ref_pc_i),
    .ref_insn_i(ref_insn_i), .ref_trap_i(ref_trap_i), .ref_rd_addr_i(ref_rd_addr_i),
    .ref_rd_wdata_i(ref_rd_wdata_i),
    .mismatch_o(mismatch_o), .mismatch_field_o(mismatch_field_o),
    .mismatch_order_o(mismatch_order_o), .match_count_o(match_count_o),
    .mismatch_count_o(mismatch_count_o), .overflow_o(overflow_o), .timeout_o(timeout_o),
    .dut_level_o(dut_level_o), .ref_level_o(ref_level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic entry_t mk(input int unsigned k);
    entry_t e;
    e.order    = 64'(k);
    e.pc       = 32'h0000_1000 + 32'(k) * 32'd4;
    e.insn     = 32'h0010_0093;
    e.trap     = 1'b0;
    e.rd_addr  = 5'(1 + (k % 31));
    e.rd_wdata = 32'hA5A5_0000 + 32'(k);
    return e;
  endfunction

  task automatic set_dut(input logic v, input entry_t e);
    dut_valid_i = v; dut_order_i = e.order; dut_pc_i = e.pc; dut_insn_i = e.insn;
    dut_trap_i = e.trap; dut_rd_addr_i = e.rd_addr; dut_rd_wdata_i = e.rd_wdata;
  endtask

  task automatic set_ref(input logic v, input entry_t e);
    ref_valid_i = v; ref_order_i = e.order; ref_pc_i = e.pc; ref_insn_i = e.insn;
    ref_trap_i = e.trap; ref_rd_addr_i = e.rd_addr; ref_rd_wdata_i = e.rd_wdata;
  endtask

  task automatic idle();
    set_dut(1'b0, '0);
    set_ref(1'b0, '0);
  endtask

  // One rising edge; returns at the following falling edge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " mismatch"}, 64'(mismatch_o), 64'd0);
    check({tag, " mask"}, 64'(mismatch_field_o), 64'd0);
    check({tag, " order"}, mismatch_order_o, 64'd0);
    check({tag, " match_count"}, 64'(match_count_o), 64'd0);
    check({tag, " mismatch_count"}, 64'(mismatch_count_o), 64'd0);
    check({tag, " overflow"}, 64'(overflow_o), 64'd0);
    check({tag, " timeout"}, 64'(timeout_o), 64'd0);
    check({tag, " dut_level"}, 64'(dut_level_o), 64'd0);
    check({tag, " ref_level"}, 64'(ref_level_o), 64'd0);
  endtask

  vec_t vecs[11];

  initial begin
    int unsigned em, emm, peak;

    for (int i = 0; i < 11; i++) begin
      vecs[i].d = mk(100 + i);
      vecs[i].r = vecs[i].d;
    end
    vecs[0].exp_mask = 6'b000000;
    vecs[1].r.pc = vecs[1].d.pc + 32'd4;               vecs[1].exp_mask = 6'b010000;
    vecs[2].d.rd_addr = 5'd0; vecs[2].r.rd_addr = 5'd0;
    vecs[2].r.rd_wdata = vecs[2].d.rd_wdata ^ 32'hFF;  vecs[2].exp_mask = 6'b000000;
    vecs[3].r.insn = vecs[3].d.insn ^ 32'h1000;        vecs[3].exp_mask = 6'b001000;
    vecs[4].r.trap = 1'b1;                             vecs[4].exp_mask = 6'b000100;
    vecs[5].r.rd_addr = vecs[5].d.rd_addr + 5'd1;      vecs[5].exp_mask = 6'b000010;
    vecs[6].d.rd_addr = 5'd0; vecs[6].r.rd_addr = 5'd5;
    vecs[6].r.rd_wdata = vecs[6].d.rd_wdata ^ 32'h1;   vecs[6].exp_mask = 6'b000010;
    vecs[7].r.rd_wdata = vecs[7].d.rd_wdata ^ 32'h8000_0000; vecs[7].exp_mask = 6'b000001;
    vecs[8].r.order = vecs[8].d.order + 64'd1;         vecs[8].exp_mask = 6'b100000;
    vecs[9].r.order = vecs[9].d.order + 64'd1;
    vecs[9].r.pc = vecs[9].d.pc + 32'd8;
    vecs[9].r.insn = vecs[9].d.insn ^ 32'h1;
    vecs[9].r.trap = 1'b1;
    vecs[9].r.rd_addr = vecs[9].d.rd_addr + 5'd1;
    vecs[9].r.rd_wdata = vecs[9].d.rd_wdata ^ 32'h3;   vecs[9].exp_mask = 6'b111111;
    vecs[10].exp_mask = 6'b000000;

    rst_i = 1'b1;
    idle();
    #12;
    @(negedge clk);
    rst_i = 1'b0;
    check_reset_state("reset");

    // Table: each pair pushed together, popped on the next edge, result checked and then held.
    em = 0; emm = 0;
    for (int i = 0; i < 11; i++) begin
      set_dut(1'b1, vecs[i].d);
      set_ref(1'b1, vecs[i].r);
      step();
      idle();
      step();
      check($sformatf("vec%0d pulse", i), 64'(mismatch_o), 64'(vecs[i].exp_mask != 6'b0));
      check($sformatf("vec%0d mask", i), 64'(mismatch_field_o), 64'(vecs[i].exp_mask));
      if (vecs[i].exp_mask != 6'b0) begin
        check($sformatf("vec%0d order", i), mismatch_order_o, vecs[i].d.order);
        emm++;
      end else begin
        em++;
      end
      step();
      check($sformatf("vec%0d pulse_end", i), 64'(mismatch_o), 64'd0);
      check($sformatf("vec%0d mask_held", i), 64'(mismatch_field_o), 64'(vecs[i].exp_mask));
    end
    check("table match_count", 64'(match_count_o), 64'(em));
    check("table mismatch_count", 64'(mismatch_count_o), 64'(emm));

    // Identical streams, back to back.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      set_dut(1'b1, mk(k));
      set_ref(1'b1, mk(k));
      step();
      if (k > 0) check($sformatf("ident%0d dut_level", k), 64'(dut_level_o), 64'd1);
    end
    idle();
    step();
    check("ident match_count", 64'(match_count_o), 64'd20);
    check("ident mismatch_count", 64'(mismatch_count_o), 64'd0);
    check("ident overflow", 64'(overflow_o), 64'd0);
    check("ident timeout", 64'(timeout_o), 64'd0);
    check("ident dut_level", 64'(dut_level_o), 64'd0);

    // Skew: reference trails the DUT by six cycles.
    do_reset();
    peak = 0;
    for (int c = 1; c <= 14; c++) begin
      set_dut(c <= 5, mk(c <= 5 ? c - 1 : 0));
      set_ref(c >= 7 && c <= 11, mk(c >= 7 ? c - 7 : 0));
      step();
      if (32'(dut_level_o) > peak) peak = 32'(dut_level_o);
    end
    idle();
    step();
    check("skew peak", 64'(peak), 64'd5);
    check("skew dut_level", 64'(dut_level_o), 64'd0);
    check("skew ref_level", 64'(ref_level_o), 64'd0);
    check("skew match_count", 64'(match_count_o), 64'd5);
    check("skew mismatch_count", 64'(mismatch_count_o), 64'd0);
    check("skew timeout", 64'(timeout_o), 64'd0);

    // Overflow: nine DUT entries, reference silent.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      set_dut(1'b1, mk(k));
      step();
      if (k == 7) begin
        check("ovf at full overflow", 64'(overflow_o), 64'd0);
        check("ovf at full level", 64'(dut_level_o), 64'd8);
      end
    end
    idle();
    check("ovf overflow", 64'(overflow_o), 64'd1);
    check("ovf dut_level", 64'(dut_level_o), 64'd8);
    check("ovf ref_level", 64'(ref_level_o), 64'd0);
    step();
    check("ovf sticky", 64'(overflow_o), 64'd1);
    do_reset();
    check_reset_state("post-ovf reset");

    // Full FIFO accepts a push when a pop happens on the same edge.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_dut(1'b1, mk(k));
      set_ref(k == 7, mk(0));
      step();
    end
    set_dut(1'b1, mk(8));
    set_ref(1'b0, mk(0));
    step();
    check("fullpop overflow", 64'(overflow_o), 64'd0);
    check("fullpop dut_level", 64'(dut_level_o), 64'd8);
    check("fullpop ref_level", 64'(ref_level_o), 64'd0);
    check("fullpop match_count", 64'(match_count_o), 64'd1);
    set_dut(1'b1, mk(9));
    step();
    idle();
    check("fullnopop overflow", 64'(overflow_o), 64'd1);
    check("fullnopop dut_level", 64'(dut_level_o), 64'd8);

    // Timeout: one DUT entry, nothing from the reference.
    do_reset();
    set_dut(1'b1, mk(0));
    step();
    idle();
    repeat (8) step();
    step();
    check("tmo cycle9", 64'(timeout_o), 64'd0);
    step();
    check("tmo cycle10", 64'(timeout_o), 64'd1);
    check("tmo dut_level", 64'(dut_level_o), 64'd1);

    // Partner arriving on the 9th unpaired cycle avoids the timeout.
    do_reset();
    set_dut(1'b1, mk(0));
    step();
    idle();
    repeat (8) step();
    set_ref(1'b1, mk(0));
    step();
    idle();
    repeat (15) step();
    check("tmo-save timeout", 64'(timeout_o), 64'd0);
    check("tmo-save match_count", 64'(match_count_o), 64'd1);
    check("tmo-save dut_level", 64'(dut_level_o), 64'd0);

    // Reset mid-stream with buffered entries clears levels without a clock edge.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_dut(1'b1, mk(k));
      step();
    end
    idle();
    check("midrst level before", 64'(dut_level_o), 64'd3);
    #2;
    rst_i = 1'b1;
    #1;
    check("midrst dut_level async", 64'(dut_level_o), 64'd0);
    check("midrst ref_level async", 64'(ref_level_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_dut(1'b1, mk(50 + k));
      set_ref(1'b1, mk(50 + k));
      step();
    end
    idle();
    step();
    check("midrst match_count", 64'(match_count_o), 64'd5);
    check("midrst mismatch_count", 64'(mismatch_count_o), 64'd0);
    check("midrst overflow", 64'(overflow_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
